arcade_input_scanner: RTL and testbench

ARCADE_INPUT_SCANNER -- requirements
Module: arcade_input_scanner

---
 rtl/arcade_input_scanner.sv | 225 ++++++++++++++++++++++
 tb/tb_arcade_input_scanner.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_scanner.sv
// Debounced arcade button scanner that streams a header + snapshot frame on every accepted change.
// Optional idle heartbeat frames (header 0xA6) are built when ARCADE_SCAN_HEARTBEAT_EN is defined.
module arcade_input_scanner #(
    parameter int CHANNELS        = 8,
    parameter int TICK_CYCLES     = 48000,
    parameter int STABLE_TICKS    = 3,
    parameter int HEARTBEAT_TICKS = 1000
) (
    input  logic                clk,
    input  logic                rst_i,
    input  logic [CHANNELS-1:0] inputs_i,
    output logic [CHANNELS-1:0] state_o,
    output logic [7:0]          data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [7:0]          coalesce_cnt_o
);

    localparam int NB = (CHANNELS + 7) / 8;
    localparam int SW = NB * 8;
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NB - 1);
    localparam logic [1:0]    STABLE_CNT = 2'(STABLE_TICKS);

    if ((CHANNELS < 1) || (CHANNELS > 32) || (STABLE_TICKS < 1) || (STABLE_TICKS > 3) ||
        (TICK_CYCLES < 1) || (HEARTBEAT_TICKS < 1)) begin : g_param_check
        $error("arcade_input_scanner: parameter out of legal range");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } fsm_t;

    logic [CHANNELS-1:0]      sync1_r;
    logic [CHANNELS-1:0]      sync2_r;
    logic [PW-1:0]            presc_r;
    logic                     tick_s;
    logic [CHANNELS-1:0][1:0] cnt_r;
    logic [CHANNELS-1:0][1:0] cnt_nxt_s;
    logic [CHANNELS-1:0]      state_r;
    logic [CHANNELS-1:0]      state_nxt_s;
    logic                     upd_s;
    fsm_t                     fsm_r;
    logic [SW-1:0]            snap_r;
    logic [IW-1:0]            idx_r;
    logic [IW-1:0]            idx_nxt_s;
    logic                     pending_r;
    logic [7:0]               coal_r;
    logic                     valid_r;
    logic [7:0]               data_r;
    logic                     start_s;
    logic [7:0]               hdr_s;

    function automatic logic [7:0] pick_byte(input logic [SW-1:0] vec, input logic [IW-1:0] sel);
        logic [7:0] res;
        res = 8'h00;
        for (int b = 0; b < NB; b++) begin
            if (IW'(b) == sel) begin
                res = vec[b*8 +: 8];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Two-flop synchroniser for the raw button lines
    always_ff @(posedge clk) begin
        if (rst_i) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= inputs_i;
            sync2_r <= sync1_r;
        end
    end

    // Sample-tick prescaler
    always_ff @(posedge clk) begin
        if (rst_i) begin
            presc_r <= '0;
        end else if (presc_r == TICK_LAST) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    assign tick_s = (presc_r == TICK_LAST);

    // Per-channel stability counters; a change is accepted only after STABLE_TICKS disagreeing ticks
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        upd_s       = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (tick_s) begin
                if (sync2_r[i] != state_r[i]) begin
                    if ((cnt_r[i] + 2'd1) == STABLE_CNT) begin
                        state_nxt_s[i] = sync2_r[i];
                        cnt_nxt_s[i]   = 2'd0;
                        upd_s          = 1'b1;
                    end else begin
                        cnt_nxt_s[i]   = cnt_r[i] + 2'd1;
                    end
                end else begin
                    cnt_nxt_s[i] = 2'd0;
                end
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
            end
        end
    end

    // Debounced state register
    always_ff @(posedge clk) begin
        if (rst_i) begin
            cnt_r   <= '0;
            state_r <= '0;
        end else begin
            cnt_r   <= cnt_nxt_s;
            state_r <= state_nxt_s;
        end
    end

`ifdef ARCADE_SCAN_HEARTBEAT_EN
    localparam int HW = $clog2(HEARTBEAT_TICKS + 1);
    localparam logic [HW-1:0] HB_LAST = HW'(HEARTBEAT_TICKS);

    logic [HW-1:0] hb_cnt_r;
    logic          hb_due_s;

    assign hb_due_s = (hb_cnt_r == HB_LAST);
    assign start_s  = (fsm_r == ST_IDLE) && (pending_r || hb_due_s);
    assign hdr_s    = pending_r ? 8'hA5 : 8'hA6;

    // Ticks since the last frame start, saturating so a late IDLE still fires the heartbeat
    always_ff @(posedge clk) begin
        if (rst_i) begin
            hb_cnt_r <= '0;
        end else if (start_s) begin
            hb_cnt_r <= '0;
        end else if (tick_s && !hb_due_s) begin
            hb_cnt_r <= hb_cnt_r + HW'(1);
        end else begin
            hb_cnt_r <= hb_cnt_r;
        end
    end
`else
    assign start_s = (fsm_r == ST_IDLE) && pending_r;
    assign hdr_s   = 8'hA5;
`endif

    assign idx_nxt_s = idx_r + IW'(1);

    // Frame FSM with pending/coalesce bookkeeping; a new update beats the pending clear
    always_ff @(posedge clk) begin
        if (rst_i) begin
            fsm_r     <= ST_IDLE;
            snap_r    <= '0;
            idx_r     <= '0;
            pending_r <= 1'b0;
            coal_r    <= 8'h00;
            valid_r   <= 1'b0;
            data_r    <= 8'h00;
        end else begin
            if (upd_s) begin
                pending_r <= 1'b1;
            end else if (start_s) begin
                pending_r <= 1'b0;
            end
            if (upd_s && pending_r && (coal_r != 8'hFF)) begin
                coal_r <= coal_r + 8'd1;
            end
            case (fsm_r)
                ST_IDLE: begin
                    if (start_s) begin
                        snap_r  <= SW'(state_r);
                        idx_r   <= '0;
                        data_r  <= hdr_s;
                        valid_r <= 1'b1;
                        fsm_r   <= ST_HEADER;
                    end else begin
                        valid_r <= 1'b0;
                        data_r  <= 8'h00;
                    end
                end
                ST_HEADER: begin
                    if (ready_i) begin
                        idx_r  <= '0;
                        data_r <= pick_byte(snap_r, '0);
                        fsm_r  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (ready_i) begin
                        if (idx_r == IDX_LAST) begin
                            valid_r <= 1'b0;
                            data_r  <= 8'h00;
                            fsm_r   <= ST_IDLE;
                        end else begin
                            idx_r  <= idx_nxt_s;
                            data_r <= pick_byte(snap_r, idx_nxt_s);
                        end
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    data_r  <= 8'h00;
                    fsm_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign state_o        = state_r;
    assign data_o         = data_r;
    assign valid_o        = valid_r;
    assign coalesce_cnt_o = coal_r;

endmodule

// File: tb/tb_arcade_input_scanner.sv
// Scoreboard bench for arcade_input_scanner: expected stream bytes are queued when inputs are
// driven and popped on every valid/ready transfer. Heartbeat checks build with ARCADE_SCAN_HEARTBEAT_EN.
module tb_arcade_input_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in8;
    logic [7:0]  state8;
    logic [7:0]  data8;
    logic        valid8;
    logic        ready8;
    logic [7:0]  coal8;
    logic [11:0] in12;
    logic [11:0] state12;
    logic [7:0]  data12;
    logic        valid12;
    logic        ready12;
    logic [7:0]  coal12;

    int          n_total = 0;
    int          n_bad   = 0;
    int          cyc     = 0;
    int          vtot8   = 0;
    int          v0;
    logic [7:0]  exp8[$];
    logic [7:0]  exp12[$];

    always #5 clk = ~clk;

    arcade_input_scanner #(
        .CHANNELS(8), .TICK_CYCLES(4), .STABLE_TICKS(2), .HEARTBEAT_TICKS(100000)
    ) dut8 (
        .clk(clk), .rst_i(rst), .inputs_i(in8), .state_o(state8), .data_o(data8),
        .valid_o(valid8), .ready_i(ready8), .coalesce_cnt_o(coal8)
    );

    arcade_input_scanner #(
        .CHANNELS(12), .TICK_CYCLES(4), .STABLE_TICKS(2), .HEARTBEAT_TICKS(100000)
    ) dut12 (
        .clk(clk), .rst_i(rst), .inputs_i(in12), .state_o(state12), .data_o(data12),
        .valid_o(valid12), .ready_i(ready12), .coalesce_cnt_o(coal12)
    );

`ifdef ARCADE_SCAN_HEARTBEAT_EN
    logic        rst_hb;
    logic [7:0]  in_hb;
    logic [7:0]  state_hb;
    logic [7:0]  data_hb;
    logic        valid_hb;
    logic        ready_hb;
    logic [7:0]  coal_hb;
    logic        hb_prev = 1'b0;
    int          hb_last = 0;
    int          hb_frames = 0;
    int          hb_pos = 0;

    arcade_input_scanner #(
        .CHANNELS(8), .TICK_CYCLES(4), .STABLE_TICKS(2), .HEARTBEAT_TICKS(5)
    ) dut_hb (
        .clk(clk), .rst_i(rst_hb), .inputs_i(in_hb), .state_o(state_hb), .data_o(data_hb),
        .valid_o(valid_hb), .ready_i(ready_hb), .coalesce_cnt_o(coal_hb)
    );
`endif

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: observe transfers at the falling edge, return 1 time unit after the rising edge
    task automatic step();
        @(negedge clk);
        cyc++;
        if (!rst) begin
            if (valid8) vtot8++;
            if (valid8 && ready8) begin
                if (exp8.size() == 0) check_val("sb8_unexpected", 32'(data8), 32'h100);
                else check_val("sb8_byte", 32'(data8), 32'(exp8.pop_front()));
            end
            if (valid12 && ready12) begin
                if (exp12.size() == 0) check_val("sb12_unexpected", 32'(data12), 32'h100);
                else check_val("sb12_byte", 32'(data12), 32'(exp12.pop_front()));
            end
        end
`ifdef ARCADE_SCAN_HEARTBEAT_EN
        if (!rst_hb) begin
            if (valid_hb && !hb_prev) begin
                if (hb_frames > 0) check_val("hb_period", 32'(cyc - hb_last), 32'd20);
                hb_last = cyc;
                hb_frames++;
            end
            if (valid_hb && ready_hb) begin
                check_val("hb_byte", 32'(data_hb), (hb_pos == 0) ? 32'hA6 : 32'h00);
                hb_pos = 1 - hb_pos;
            end
            hb_prev = valid_hb;
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in8  = 8'h00;
        in12 = 12'h000;
        rst  = 1'b1;
        repeat (3) step();
        rst  = 1'b0;
        exp8.delete();
        exp12.delete();
    endtask

    task automatic wait_valid8(input string tag);
        for (int i = 0; i < 20 && !valid8; i++) step();
        check_val(tag, 32'(valid8), 32'd1);
    endtask

    initial begin
        rst     = 1'b1;
        in8     = 8'h00;
        in12    = 12'h000;
        ready8  = 1'b1;
        ready12 = 1'b1;
`ifdef ARCADE_SCAN_HEARTBEAT_EN
        rst_hb   = 1'b1;
        in_hb    = 8'h00;
        ready_hb = 1'b1;
`endif
        #1;
        repeat (4) step();
        check_val("rst_state", 32'(state8), 32'h0);
        check_val("rst_valid", 32'(valid8), 32'h0);
        check_val("rst_data", 32'(data8), 32'h0);
        check_val("rst_coal", 32'(coal8), 32'h0);
        check_val("rst_valid12", 32'(valid12), 32'h0);
        rst = 1'b0;
`ifdef ARCADE_SCAN_HEARTBEAT_EN
        rst_hb = 1'b0;
`endif

        // Basic change 0x00 -> 0x81
        in8 = 8'h81;
        exp8.push_back(8'hA5);
        exp8.push_back(8'h81);
        v0 = vtot8;
        for (int k = 0; k < 11 && state8 != 8'h81; k++) step();
        check_val("t1_state", 32'(state8), 32'h81);
        repeat (10) step();
        check_val("t1_valid_cycles", 32'(vtot8 - v0), 32'd2);
        check_val("t1_drain", 32'(exp8.size()), 32'd0);
        check_val("t1_coal", 32'(coal8), 32'd0);

        // One-tick glitch is filtered
        do_reset();
        v0 = vtot8;
        in8 = 8'h01;
        repeat (4) step();
        in8 = 8'h00;
        repeat (24) step();
        check_val("t2_state", 32'(state8), 32'h0);
        check_val("t2_no_valid", 32'(vtot8 - v0), 32'd0);
        check_val("t2_coal", 32'(coal8), 32'd0);

        // Backpressure holds the header
        do_reset();
        ready8 = 1'b0;
        in8 = 8'h3C;
        exp8.push_back(8'hA5);
        exp8.push_back(8'h3C);
        wait_valid8("t3_hdr_timeout");
        for (int k = 0; k < 10; k++) begin
            check_val("t3_hold_data", 32'(data8), 32'hA5);
            check_val("t3_hold_valid", 32'(valid8), 32'd1);
            step();
        end
        ready8 = 1'b1;
        repeat (6) step();
        check_val("t3_drain", 32'(exp8.size()), 32'd0);
        check_val("t3_state", 32'(state8), 32'h3C);

        // Coalescing while the sink is stalled
        do_reset();
        ready8 = 1'b0;
        in8 = 8'h01;
        repeat (12) step();
        in8 = 8'h03;
        repeat (12) step();
        in8 = 8'h07;
        repeat (12) step();
        check_val("t4_coal_stalled", 32'(coal8), 32'd1);
        exp8.push_back(8'hA5);
        exp8.push_back(8'h01);
        exp8.push_back(8'hA5);
        exp8.push_back(8'h07);
        ready8 = 1'b1;
        repeat (20) step();
        check_val("t4_drain", 32'(exp8.size()), 32'd0);
        check_val("t4_coal", 32'(coal8), 32'd1);
        check_val("t4_state", 32'(state8), 32'h07);

        // 12-channel frame has two data bytes, upper nibble zero-padded
        in12 = 12'hFFF;
        exp12.push_back(8'hA5);
        exp12.push_back(8'hFF);
        exp12.push_back(8'h0F);
        repeat (25) step();
        check_val("t5_drain", 32'(exp12.size()), 32'd0);
        check_val("t5_state", 32'(state12), 32'hFFF);
        check_val("t5_coal", 32'(coal12), 32'd0);

        // Reset aborts a frame with its data byte pending
        do_reset();
        ready8 = 1'b0;
        in8 = 8'h55;
        exp8.push_back(8'hA5);
        exp8.push_back(8'h55);
        wait_valid8("t6_hdr_timeout");
        ready8 = 1'b1;
        step();
        ready8 = 1'b0;
        step();
        check_val("t6_data_byte", 32'(data8), 32'h55);
        check_val("t6_data_valid", 32'(valid8), 32'd1);
        check_val("t6_left", 32'(exp8.size()), 32'd1);
        rst = 1'b1;
        in8 = 8'h00;
        ready8 = 1'b1;
        step();
        check_val("t6_rst_valid", 32'(valid8), 32'd0);
        check_val("t6_rst_state", 32'(state8), 32'h0);
        check_val("t6_rst_data", 32'(data8), 32'h0);
        rst = 1'b0;
        exp8.delete();
        v0 = vtot8;
        repeat (24) step();
        check_val("t6_no_more", 32'(vtot8 - v0), 32'd0);

`ifdef ARCADE_SCAN_HEARTBEAT_EN
        check_val("hb_frames_seen", 32'(hb_frames >= 3), 32'd1);
        check_val("hb_state", 32'(state_hb), 32'h0);
        check_val("hb_coal", 32'(coal_hb), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
